// File: rtl/bus_dest_bank_pkg.sv
// bus_dest_bank_pkg: shared widths, operation encoding and bus register indices
package bus_dest_bank_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int NREGS_DEF = 8;
    typedef enum logic [1:0] {OP_NONE, OP_CLR, OP_LD, OP_INR} op_e;
    localparam logic [2:0] AR = 3'd1;
    localparam logic [2:0] PC = 3'd2;
    localparam logic [2:0] DR = 3'd3;
    localparam logic [2:0] AC = 3'd4;
    localparam logic [2:0] IR = 3'd5;
    localparam logic [2:0] TR = 3'd6;
    localparam logic [2:0] MEM = 3'd7;
    function automatic op_e resolve_op(input logic clr, input logic ld, input logic inr);
        return clr ? OP_CLR : ld ? OP_LD : inr ? OP_INR : OP_NONE;
    endfunction
endpackage

// File: rtl/bus_dest_reg.sv
// bus_dest_reg: one destination register with clr>ld>inr and a sticky wrap flag
module bus_dest_reg
    import bus_dest_bank_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             ld,
    input  logic             inr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             ovf
);
    op_e op;
    assign op = en ? resolve_op(clr, ld, inr) : OP_NONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            ovf <= 1'b0;
        end else begin
            q   <= op == OP_CLR ? '0 : op == OP_LD ? d : op == OP_INR ? q + WIDTH'(1) : q;
            ovf <= op == OP_CLR ? 1'b0 : (op == OP_INR && &q) ? 1'b1 : ovf;
        end
    end
endmodule

// File: rtl/bus_dest_bank.sv
// bus_dest_bank: routes the common bus into one of eight destination registers
module bus_dest_bank
    import bus_dest_bank_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [2:0]       dest_sel,
    input  logic             ld,
    input  logic             inr,
    input  logic             clr,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7,
    output logic [7:0]       ovf,
    output logic             done,
    output logic [2:0]       last_dest
);
    logic [NREGS-1:0] en;
    logic [WIDTH-1:0] qs [NREGS];
    logic             any_op;
    assign en     = NREGS'(1) << dest_sel;
    assign any_op = ld | inr | clr;
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        bus_dest_reg #(.WIDTH(WIDTH)) u_reg (
            .clk(clk),
            .rst(rst),
            .en (en[i]),
            .clr(clr),
            .ld (ld),
            .inr(inr),
            .d  (bus_in),
            .q  (qs[i]),
            .ovf(ovf[i])
        );
    end
    assign q0 = qs[0];
    assign q1 = qs[1];
    assign q2 = qs[2];
    assign q3 = qs[3];
    assign q4 = qs[4];
    assign q5 = qs[5];
    assign q6 = qs[6];
    assign q7 = qs[7];
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            last_dest <= 3'd0;
        end else begin
            done      <= any_op;
            last_dest <= any_op ? dest_sel : last_dest;
        end
    end
endmodule
